// File: rtl/election_controller_pkg.sv
// Shared phase encodings and widths for the election session sequencer.
package election_controller_pkg;

  localparam int PHASE_W   = 3;
  localparam int BALLOTS_W = 16;

  typedef enum logic [PHASE_W-1:0] {
    PH_IDLE    = 3'd0,
    PH_WAIT    = 3'd1,
    PH_BALLOT  = 3'd2,
    PH_LOCKOUT = 3'd3,
    PH_CLOSED  = 3'd4
  } phase_e;

endpackage

// File: rtl/election_controller_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr_i and rises modulo NUM_CAND.
module rr_arbiter #(
  parameter int NUM_CAND = 4
) (
  input  logic [NUM_CAND-1:0]         req_i,
  input  logic [$clog2(NUM_CAND)-1:0] ptr_i,
  output logic [NUM_CAND-1:0]         grant_o,
  output logic [$clog2(NUM_CAND)-1:0] idx_o,
  output logic                        multi_hit_o
);

  localparam int CW = $clog2(NUM_CAND);

  logic          found;
  logic [CW:0]   sum;
  logic [CW-1:0] k;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    sum     = '0;
    k       = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      // ptr and offset are both below NUM_CAND, so one subtraction wraps the sum
      sum = {1'b0, ptr_i} + (CW+1)'(i);
      if (sum >= (CW+1)'(NUM_CAND)) sum = sum - (CW+1)'(NUM_CAND);
      k = sum[CW-1:0];
      if (!found && req_i[k]) begin
        found      = 1'b1;
        grant_o[k] = 1'b1;
        idx_o      = k;
      end
    end
  end

  assign multi_hit_o = |(req_i & (req_i - NUM_CAND'(1)));

endmodule

// File: rtl/election_controller.sv
// Election session sequencer: phase FSM, ballot/lockout/scan timer and vote grant path.
// state      | meaning
// PH_IDLE    | election not opened yet
// PH_WAIT    | open, waiting for an officer to authorise a ballot
// PH_BALLOT  | one ballot open, first vote_req wins
// PH_LOCKOUT | vote acknowledged, further presses ignored
// PH_CLOSED  | terminal, cycling through results
module election_controller
  import election_controller_pkg::*;
#(
  parameter int NUM_CAND       = 4,
  parameter int BALLOT_TIMEOUT = 1000,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int SCAN_PERIOD    = 100
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        admin_open_i,
  input  logic                        admin_close_i,
  input  logic                        voter_auth_i,
  input  logic [NUM_CAND-1:0]         vote_req_i,
  output logic [NUM_CAND-1:0]         vote_grant_o,
  output logic                        ballot_open_o,
  output logic                        ack_led_o,
  output logic                        timeout_pulse_o,
  output logic                        collision_o,
  output logic [PHASE_W-1:0]          phase_o,
  output logic [$clog2(NUM_CAND)-1:0] result_sel_o,
  output logic                        result_valid_o,
  output logic [BALLOTS_W-1:0]        ballots_cast_o
);

  localparam int SEL_W = $clog2(NUM_CAND);

  phase_e               state_q, state_d;
  logic [31:0]          timer_q, timer_d;
  logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 close_pending_q, close_pending_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [BALLOTS_W-1:0] ballots_q, ballots_d;

  logic [NUM_CAND-1:0]  grant_q, grant_d;
  logic                 ballot_open_q, ballot_open_d;
  logic                 ack_q, ack_d;
  logic                 timeout_q, timeout_d;
  logic                 collision_q, collision_d;
  logic                 valid_q, valid_d;

  logic [NUM_CAND-1:0]  arb_grant;
  logic [SEL_W-1:0]     arb_idx;
  logic                 arb_multi;
  logic                 vote_hit;
  logic                 ballot_expire;
  logic                 close_now;

  rr_arbiter #(.NUM_CAND(NUM_CAND)) u_arb (
    .req_i       (vote_req_i),
    .ptr_i       (rr_ptr_q),
    .grant_o     (arb_grant),
    .idx_o       (arb_idx),
    .multi_hit_o (arb_multi)
  );

  assign vote_hit      = (state_q == PH_BALLOT) && (|vote_req_i);
  assign ballot_expire = (state_q == PH_BALLOT) && (timer_q == 32'd0) && !(|vote_req_i);
  assign close_now     = close_pending_q | admin_close_i;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q         <= PH_IDLE;
      timer_q         <= '0;
      rr_ptr_q        <= '0;
      close_pending_q <= 1'b0;
      sel_q           <= '0;
      ballots_q       <= '0;
      grant_q         <= '0;
      ballot_open_q   <= 1'b0;
      ack_q           <= 1'b0;
      timeout_q       <= 1'b0;
      collision_q     <= 1'b0;
      valid_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      rr_ptr_q        <= rr_ptr_d;
      close_pending_q <= close_pending_d;
      sel_q           <= sel_d;
      ballots_q       <= ballots_d;
      grant_q         <= grant_d;
      ballot_open_q   <= ballot_open_d;
      ack_q           <= ack_d;
      timeout_q       <= timeout_d;
      collision_q     <= collision_d;
      valid_q         <= valid_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    rr_ptr_d        = rr_ptr_q;
    close_pending_d = close_pending_q;
    sel_d           = sel_q;
    ballots_d       = ballots_q;
    case (state_q)
      PH_IDLE: begin
        if (admin_open_i) state_d = PH_WAIT;
      end
      PH_WAIT: begin
        if (admin_close_i) begin
          state_d = PH_CLOSED;
          timer_d = 32'(SCAN_PERIOD - 1);
          sel_d   = '0;
        end else if (voter_auth_i) begin
          state_d = PH_BALLOT;
          timer_d = 32'(BALLOT_TIMEOUT - 1);
        end
      end
      PH_BALLOT: begin
        if (admin_close_i) close_pending_d = 1'b1;
        if (vote_hit) begin
          state_d  = PH_LOCKOUT;
          timer_d  = 32'(LOCKOUT_CYCLES - 1);
          rr_ptr_d = (arb_idx == SEL_W'(NUM_CAND - 1)) ? '0 : arb_idx + SEL_W'(1);
          if (ballots_q != '1) ballots_d = ballots_q + BALLOTS_W'(1);
        end else if (timer_q == 32'd0) begin
          if (close_now) begin
            state_d = PH_CLOSED;
            timer_d = 32'(SCAN_PERIOD - 1);
            sel_d   = '0;
          end else begin
            state_d = PH_WAIT;
          end
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      PH_LOCKOUT: begin
        if (admin_close_i) close_pending_d = 1'b1;
        if (timer_q == 32'd0) begin
          if (close_now) begin
            state_d = PH_CLOSED;
            timer_d = 32'(SCAN_PERIOD - 1);
            sel_d   = '0;
          end else begin
            state_d = PH_WAIT;
          end
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      PH_CLOSED: begin
        if (timer_q == 32'd0) begin
          timer_d = 32'(SCAN_PERIOD - 1);
          sel_d   = (sel_q == SEL_W'(NUM_CAND - 1)) ? '0 : sel_q + SEL_W'(1);
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      default: state_d = PH_IDLE;
    endcase
  end

  // Flags are registered off the next state so they line up with phase_o.
  always_comb begin
    grant_d       = vote_hit ? arb_grant : '0;
    collision_d   = vote_hit & arb_multi;
    timeout_d     = ballot_expire;
    ballot_open_d = (state_d == PH_BALLOT);
    ack_d         = (state_d == PH_LOCKOUT);
    valid_d       = (state_d == PH_CLOSED);
  end

  assign vote_grant_o    = grant_q;
  assign ballot_open_o   = ballot_open_q;
  assign ack_led_o       = ack_q;
  assign timeout_pulse_o = timeout_q;
  assign collision_o     = collision_q;
  assign phase_o         = state_q;
  assign result_sel_o    = sel_q;
  assign result_valid_o  = valid_q;
  assign ballots_cast_o  = ballots_q;

endmodule

// File: tb/tb_election_controller.sv
// Directed bench for election_controller with hand-computed expectations.
module tb_election_controller;

  logic        clk;
  logic        reset;
  logic        admin_open, admin_close, voter_auth;
  logic [3:0]  vote_req;
  logic [3:0]  vote_grant;
  logic        ballot_open, ack_led, timeout_pulse, collision, result_valid;
  logic [2:0]  phase;
  logic [1:0]  result_sel;
  logic [15:0] ballots_cast;

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  election_controller #(
    .NUM_CAND(4), .BALLOT_TIMEOUT(1000), .LOCKOUT_CYCLES(16), .SCAN_PERIOD(100)
  ) dut (
    .clock_i         (clk),
    .reset_i         (reset),
    .admin_open_i    (admin_open),
    .admin_close_i   (admin_close),
    .voter_auth_i    (voter_auth),
    .vote_req_i      (vote_req),
    .vote_grant_o    (vote_grant),
    .ballot_open_o   (ballot_open),
    .ack_led_o       (ack_led),
    .timeout_pulse_o (timeout_pulse),
    .collision_o     (collision),
    .phase_o         (phase),
    .result_sel_o    (result_sel),
    .result_valid_o  (result_valid),
    .ballots_cast_o  (ballots_cast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; applies inputs for one rising edge and returns on the next falling edge.
  task automatic step(input logic o, input logic c, input logic a, input logic [3:0] r);
    admin_open = o; admin_close = c; voter_auth = a; vote_req = r;
    @(negedge clk);
    admin_open = 1'b0; admin_close = 1'b0; voter_auth = 1'b0; vote_req = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    admin_open = 1'b0; admin_close = 1'b0; voter_auth = 1'b0; vote_req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_phase(input string tag, input logic [2:0] exp, input int budget);
    int k = 0;
    while (phase !== exp && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, phase, exp);
  endtask

  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_phase", phase, 0);
    chk("rst_grant", vote_grant, 0);
    chk("rst_ballot_open", ballot_open, 0);
    chk("rst_ack", ack_led, 0);
    chk("rst_timeout", timeout_pulse, 0);
    chk("rst_collision", collision, 0);
    chk("rst_sel", result_sel, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_ballots", ballots_cast, 0);

    // basic vote and lockout length
    step(1, 0, 0, 4'b0000);
    chk("t1_wait", phase, 1);
    step(0, 0, 1, 4'b0000);
    chk("t1_ballot", phase, 2);
    chk("t1_ballot_open", ballot_open, 1);
    step(0, 0, 0, 4'b0100);
    chk("t1_grant", vote_grant, 4'b0100);
    chk("t1_lockout", phase, 3);
    chk("t1_ack", ack_led, 1);
    chk("t1_no_collision", collision, 0);
    chk("t1_ballots", ballots_cast, 1);
    chk("t1_ballot_closed", ballot_open, 0);
    @(negedge clk);
    chk("t1_grant_one_cycle", vote_grant, 0);
    n = 2;
    for (int i = 0; i < 40 && ack_led; i++) begin
      @(negedge clk);
      if (ack_led) n++;
    end
    chk("t1_ack_cycles", n, 16);
    chk("t1_back_wait", phase, 1);

    // round robin with full collisions
    do_reset();
    step(1, 0, 0, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1, 4'b0000);
      step(0, 0, 0, 4'b1111);
      chk("t2_rr_grant", vote_grant, rr_exp[k]);
      chk("t2_collision", collision, 1);
      wait_phase("t2_wait", 3'd1, 20);
    end
    chk("t2_ballots", ballots_cast, 5);
    step(0, 0, 1, 4'b0000);
    step(0, 0, 0, 4'b1001);
    chk("t2_pair_a", vote_grant, 4'b1000);
    chk("t2_pair_a_coll", collision, 1);
    wait_phase("t2_wait_a", 3'd1, 20);
    step(0, 0, 1, 4'b0000);
    step(0, 0, 0, 4'b0110);
    chk("t2_pair_b", vote_grant, 4'b0010);
    wait_phase("t2_wait_b", 3'd1, 20);
    chk("t2_ballots7", ballots_cast, 7);

    // ballot timeout, then vote on final cycle
    step(0, 0, 1, 4'b0000);
    chk("t3_ballot", phase, 2);
    n = 0;
    while (!timeout_pulse && n < 1100) begin
      @(negedge clk);
      n++;
    end
    chk("t3_timeout_cycle", n, 1000);
    chk("t3_timeout_pulse", timeout_pulse, 1);
    chk("t3_phase_wait", phase, 1);
    chk("t3_no_grant", vote_grant, 0);
    @(negedge clk);
    chk("t3_pulse_one_cycle", timeout_pulse, 0);
    chk("t3_ballots", ballots_cast, 7);
    step(0, 0, 1, 4'b0000);
    repeat (999) @(negedge clk);
    chk("t3_still_ballot", phase, 2);
    step(0, 0, 0, 4'b0001);
    chk("t3_last_grant", vote_grant, 4'b0001);
    chk("t3_last_no_timeout", timeout_pulse, 0);
    chk("t3_last_lockout", phase, 3);
    wait_phase("t3_wait", 3'd1, 20);

    // close during ballot, then result scan
    step(0, 0, 1, 4'b0000);
    step(0, 1, 0, 4'b0000);
    chk("t4_still_ballot", phase, 2);
    step(0, 0, 0, 4'b0010);
    chk("t4_grant", vote_grant, 4'b0010);
    chk("t4_lockout", phase, 3);
    wait_phase("t4_closed", 3'd4, 20);
    chk("t4_valid", result_valid, 1);
    chk("t4_sel0", result_sel, 0);
    chk("t4_ack_off", ack_led, 0);
    for (int k = 1; k <= 4; k++) begin
      repeat (99) @(negedge clk);
      chk("t4_sel_hold", result_sel, k - 1);
      @(negedge clk);
      chk("t4_sel_step", result_sel, k % 4);
    end

    // ignored inputs
    step(0, 0, 0, 4'b1111);
    chk("t5_closed_no_grant", vote_grant, 0);
    chk("t5_closed_phase", phase, 4);
    step(1, 0, 1, 4'b0000);
    chk("t5_closed_open", phase, 4);
    chk("t5_closed_ballots", ballots_cast, 9);
    do_reset();
    step(0, 0, 0, 4'b1111);
    chk("t5_idle_no_grant", vote_grant, 0);
    chk("t5_idle_phase", phase, 0);
    step(1, 0, 0, 4'b0000);
    step(0, 0, 0, 4'b1111);
    chk("t5_wait_no_grant", vote_grant, 0);
    chk("t5_wait_no_coll", collision, 0);
    chk("t5_wait_phase", phase, 1);
    step(0, 0, 1, 4'b0000);
    step(0, 0, 0, 4'b0100);
    chk("t5_grant", vote_grant, 4'b0100);
    step(0, 0, 0, 4'b1111);
    chk("t5_lock_no_grant", vote_grant, 0);
    chk("t5_lock_no_coll", collision, 0);
    chk("t5_lock_phase", phase, 3);
    chk("t5_lock_ballots", ballots_cast, 1);
    wait_phase("t5_wait", 3'd1, 20);

    // reset mid-ballot with a simultaneous vote
    step(0, 0, 1, 4'b0000);
    chk("t6_ballot", phase, 2);
    reset = 1'b1;
    vote_req = 4'b1111;
    @(negedge clk);
    reset = 1'b0;
    vote_req = '0;
    chk("t6_no_grant", vote_grant, 0);
    chk("t6_phase", phase, 0);
    chk("t6_ballot_open", ballot_open, 0);
    chk("t6_ballots", ballots_cast, 0);
    chk("t6_ack", ack_led, 0);
    chk("t6_coll", collision, 0);
    step(1, 0, 0, 4'b0000);
    step(0, 1, 1, 4'b0000);
    chk("t6_close_wins", phase, 4);
    chk("t6_close_no_ballot", ballot_open, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
